// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit byte port among NREQ requesters.
// Grants are held per message, bounded by a burst limit and an idle timeout.
module uart_tx_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DBIT     = 8,
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DBIT-1:0]     req_data_i,
  input  logic [NREQ-1:0]          req_last_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [DBIT-1:0]          tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [$clog2(NREQ)-1:0]  grant_id_o,
  output logic                     busy_o
);

  localparam int unsigned IdW        = $clog2(NREQ);
  localparam logic [7:0]  MaxBurst   = 8'(MAXBURST);
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  rr_q, rr_d;
  logic [IdW-1:0]  winner;
  logic [7:0]      burst_q, burst_d;
  logic [7:0]      idle_q, idle_d;
  logic            tx_valid_q, tx_valid_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic            out_free, accept, gvalid, glast, release_c;

  assign out_free = ~tx_valid_q | tx_ready_i;
  assign gvalid   = req_valid_i[grant_q];
  assign glast    = req_last_i[grant_q];
  assign accept   = (state_q == StGrant) & out_free & gvalid;

  always_comb begin
    req_ready_o = '0;
    if (state_q == StGrant && out_free) req_ready_o[grant_q] = 1'b1;
  end

  // Scan downwards so the requester closest to rr_q (lowest offset) wins.
  always_comb begin
    winner = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_q) + k) % int'(NREQ)]) begin
        winner = IdW'((int'(rr_q) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    idle_d    = idle_q;
    release_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          grant_d = winner;
          burst_d = '0;
          idle_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          burst_d   = burst_q + 8'd1;
          idle_d    = '0;
          release_c = glast | ((burst_q + 8'd1) == MaxBurst);
        end else if (!gvalid) begin
          idle_d    = idle_q + 8'd1;
          release_c = (idle_q + 8'd1) == TimeoutCnt;
        end
        if (release_c) begin
          state_d = StIdle;
          rr_d    = (int'(grant_q) == int'(NREQ) - 1) ? '0 : grant_q + IdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register drains independently of the grant FSM.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = req_data_i[int'(grant_q)*int'(DBIT) +: DBIT];
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      idle_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      idle_q     <= idle_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StGrant) | tx_valid_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit channel among NREQ byte-stream requesters.
- Grants the channel to one requester at a time and holds the grant for a whole message, up to a burst limit.
- Forwards accepted bytes through a one-entry output register to the downstream valid/ready byte port, which feeds the UART transmitter or its TXD register writer.
- Reclaims the channel from stalled requesters via an idle timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
DBIT, 8, data bits per character
MAXBURST, 16, max bytes per grant before forced release (1..255)
TIMEOUT, 64, cycles a granted requester may hold req_valid low before forced release (1..255)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester byte valid
req_data  input  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT]
req_last  input  NREQ  marks the final byte of a requester's message
req_ready  output  NREQ  per-requester byte accept
tx_data  output  DBIT  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte
grant_id  output  max(1,$clog2(NREQ))  current/last granted requester
busy  output  1  high in GRANT state or while tx_valid is high

Behaviour:
- Reset (reset low, async) forces:
  - state=IDLE; tx_valid=0; tx_data=0; req_ready=0; grant_id=0; busy=0.
  - rr_ptr=0; burst_cnt=0; idle_cnt=0.
- Reset mid-transfer discards the held output byte. Nothing is replayed.
- Accept: requester i byte accepted on a cycle with req_valid[i] & req_ready[i].
- req_ready[i] = (state==GRANT) & (grant_id==i) & (~tx_valid | tx_ready). It is combinational from registered state and tx_ready. All other bits are 0.
- Output register:
  - On accept: tx_data<=req_data[grant], tx_valid<=1, at the next clock edge. Latency is 1 cycle.
  - Otherwise, on tx_valid & tx_ready: tx_valid<=0.
  - Simultaneous drain and accept gives back-to-back bytes with no bubble.
  - tx_data holds stable while tx_valid & ~tx_ready.
- FSM, 2 states:
  - IDLE, no req_valid: stay.
  - IDLE, some req_valid: winner = first set bit of req_valid scanning rr_ptr, rr_ptr+1, ... mod NREQ.
    - grant_id<=winner; burst_cnt<=0; idle_cnt<=0; go to GRANT.
    - Arbitration costs 1 cycle, so the first accept is possible the cycle after entering GRANT.
  - GRANT: on each accept, burst_cnt<=burst_cnt+1 and idle_cnt<=0.
  - GRANT: on a cycle with req_valid[grant_id]=0, idle_cnt<=idle_cnt+1.
  - GRANT: on a cycle with req_valid[grant_id]=1 but no accept (output stalled), idle_cnt holds.
  - GRANT -> IDLE with rr_ptr<=(grant_id+1) mod NREQ when any of these hold:
    - (a) the accepted byte has req_last[grant_id]=1;
    - (b) an accept makes burst_cnt+1==MAXBURST;
    - (c) idle_cnt+1==TIMEOUT while req_valid[grant_id]=0.
  - If (a), (b) and (c) coincide, a single release occurs.
  - The output register keeps draining after release, independent of the FSM.
- grant_id holds its value in IDLE, showing the last grant.
- Fairness: a continuously requesting peer waits at most (NREQ-1) grants. Each grant is bounded by MAXBURST bytes or TIMEOUT idle cycles.
- Requesters not granted see req_ready=0 and must hold their data (standard valid/ready; the scheduler never drops data).
- req_last is ignored unless accompanied by an accept.
- Counters are 8 bits wide and never wrap, because release occurs at the limit.

Test Plan:
- Reset, then req_valid=0 for 10 cycles -> tx_valid=0, req_ready=0, busy=0, grant_id=0.
- Req 2 sends 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> tx_data 0x41,0x42,0x43 on consecutive cycles, each 1 cycle after its accept. grant_id=2. FSM returns to IDLE after 0x43 and rr_ptr=3.
- All 4 requesters valid continuously, each message 2 bytes with last on the 2nd, tx_ready=1 -> grant order 0,1,2,3,0. Each grant passes exactly 2 bytes. There is 1 idle arbitration cycle between grants.
- MAXBURST=16, req 1 streams 20 bytes with no last, req 3 also valid -> after 16 bytes grant moves to 3. Req 1 resumes with its 17th byte on its next grant. No byte is lost or duplicated.
- Req 0 granted, sends 1 byte, then drops req_valid; TIMEOUT=64 -> release exactly 64 cycles after valid drops. Req 2, pending, is granted on the following cycle.
- tx_ready=0 for 5 cycles with tx_valid=1 -> tx_data stable, req_ready=0, idle_cnt not incremented. Then tx_ready=1 -> the held byte drains and the next byte is accepted in the same cycle.
- Assert reset mid-burst with tx_valid=1 -> tx_valid=0 immediately (asynchronously). After release of reset, arbitration starts from requester 0.
